// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 256-point FFT pipeline.
package fft_pkg;

    localparam int unsigned FFT_LOG2N = 8;
    localparam int unsigned FFT_N     = 1 << FFT_LOG2N;

    // Read-side FSM of the output reorder buffer.
    typedef enum logic [0:0] {
        StIdle,
        StRead
    } rd_state_e;

    // Reverse the bit order of a frame index.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] x);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = x[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fft_reorder_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; holds last data when not enabled.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/fft256_bitrev_reorder.sv
// Output reorder buffer for the 256-point SDF FFT: bit-reversed frames in,
// natural-order frames out, ping-pong banks so back-to-back frames never stall.
// Optional macro FFT_REORDER_XPROP_EN: drive X on do_re/do_im while do_en=0.
module fft256_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOG2N = FFT_LOG2N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned AW = LOG2N + 1;
    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

`ifdef FFT_REORDER_XPROP_EN
    localparam logic [WIDTH-1:0] IdleData = {WIDTH{1'bx}};
`else
    localparam logic [WIDTH-1:0] IdleData = '0;
`endif

    logic [LOG2N-1:0] wr_count_q, wr_count_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] rd_count_q, rd_count_d;
    logic             rd_bank_q, rd_bank_d;
    rd_state_e        state_q, state_d;
    logic             frame_done;

    logic             ram_re;
    logic [AW-1:0]    ram_waddr;
    logic [AW-1:0]    ram_raddr;
    logic [DW-1:0]    ram_rdata;

    logic             do_en_q;
    logic [WIDTH-1:0] do_re_q, do_im_q;
    logic             out_valid;

    assign frame_done = di_en && (wr_count_q == LastIdx);

    // Write side: count consecutive valid samples, toggle bank on a full frame.
    always_comb begin
        wr_count_d = wr_count_q;
        wr_bank_d  = wr_bank_q;
        if (!di_en) begin
            wr_count_d = '0;
        end else begin
            wr_count_d = wr_count_q + LOG2N'(1);
            if (frame_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    // Read FSM next state; a frame landing on the last read chains without a bubble.
    always_comb begin
        state_d    = state_q;
        rd_count_d = rd_count_q;
        rd_bank_d  = rd_bank_q;
        unique case (state_q)
            StIdle: begin
                if (frame_done) begin
                    state_d    = StRead;
                    rd_bank_d  = wr_bank_q;
                    rd_count_d = '0;
                end
            end
            StRead: begin
                if (rd_count_q == LastIdx) begin
                    if (frame_done) begin
                        rd_bank_d  = wr_bank_q;
                        rd_count_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    rd_count_d = rd_count_q + LOG2N'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Address the RAM with next-state values so read data lines up with state_q,
    // giving two cycles from last input to first output.
    assign ram_re    = (state_d == StRead);
    assign ram_raddr = {rd_bank_d, rd_count_d};
    assign ram_waddr = {wr_bank_q, bitrev(wr_count_q)};
    assign out_valid = (state_q == StRead);

    fft_reorder_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (di_en),
        .waddr_i (ram_waddr),
        .wdata_i ({di_re, di_im}),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Counters, bank flags and FSM state.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count_q <= '0;
            wr_bank_q  <= 1'b0;
            rd_count_q <= '0;
            rd_bank_q  <= 1'b0;
            state_q    <= StIdle;
        end else begin
            wr_count_q <= wr_count_d;
            wr_bank_q  <= wr_bank_d;
            rd_count_q <= rd_count_d;
            rd_bank_q  <= rd_bank_d;
            state_q    <= state_d;
        end
    end

    // Output register; data is forced to the idle value whenever invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            do_en_q <= 1'b0;
            do_re_q <= IdleData;
            do_im_q <= IdleData;
        end else begin
            do_en_q <= out_valid;
            do_re_q <= out_valid ? ram_rdata[DW-1:WIDTH] : IdleData;
            do_im_q <= out_valid ? ram_rdata[WIDTH-1:0] : IdleData;
        end
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

endmodule

// File: tb/tb_fft256_bitrev_reorder.sv
// Self-checking bench for fft256_bitrev_reorder: a per-cycle expectation
// schedule is built from whole received frames and compared every cycle.
module tb_fft256_bitrev_reorder;
    import fft_pkg::*;

    localparam int MAXC = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        di_en = 1'b0;
    logic [15:0] di_re = '0;
    logic [15:0] di_im = '0;
    logic        do_en;
    logic [15:0] do_re;
    logic [15:0] do_im;

    fft256_bitrev_reorder #(
        .WIDTH (16),
        .LOG2N (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit check_on = 1'b0;

    // Expected output per cycle.
    bit          exp_en [MAXC];
    logic [15:0] exp_re [MAXC];
    logic [15:0] exp_im [MAXC];

    // Model of the write side: samples of the frame currently arriving.
    logic [15:0] fr_re [256];
    logic [15:0] fr_im [256];
    int          fr_cnt = 0;
    int          last_done = 0;

    int cur_run = 0;
    int max_run = 0;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Frame arrival k carries bin bitrev(k); output m must be bin m.
    task automatic model_step(input bit rst, input bit en, input logic [15:0] re,
                              input logic [15:0] im);
        if (rst) begin
            fr_cnt = 0;
            for (int t = cyc + 1; t < MAXC; t++) exp_en[t] = 1'b0;
        end else if (en) begin
            fr_re[fr_cnt] = re;
            fr_im[fr_cnt] = im;
            if (fr_cnt == 255) begin
                last_done = cyc;
                for (int m = 0; m < 256; m++) begin
                    if (cyc + 2 + m < MAXC) begin
                        exp_en[cyc + 2 + m] = 1'b1;
                        exp_re[cyc + 2 + m] = fr_re[bitrev(8'(m))];
                        exp_im[cyc + 2 + m] = fr_im[bitrev(8'(m))];
                    end
                end
                fr_cnt = 0;
            end else begin
                fr_cnt++;
            end
        end else begin
            fr_cnt = 0;
        end
    endtask

    task automatic tick(input bit rst, input bit en, input logic [15:0] re,
                        input logic [15:0] im);
        @(posedge clock);
        #1;
        cyc++;
        reset = rst;
        di_en = en;
        di_re = re;
        di_im = im;
        if (cyc >= 2) check_on = 1'b1;
        model_step(rst, en, re, im);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    // mode 0: re=bitrev(k), im=k; mode 1: re=bitrev(k)+256*f, im random; else random.
    task automatic send_frame(input int n, input int mode, input int f);
        logic [15:0] re, im;
        for (int k = 0; k < n; k++) begin
            if (mode == 0) begin
                re = 16'(bitrev(8'(k)));
                im = 16'(k);
            end else if (mode == 1) begin
                re = 16'(bitrev(8'(k))) + 16'(256 * f);
                im = 16'($urandom);
            end else begin
                re = 16'($urandom);
                im = 16'($urandom);
            end
            tick(1'b0, 1'b1, re, im);
        end
    endtask

    // Per-cycle compare of DUT outputs against the schedule.
    always @(negedge clock) begin
        if (check_on && cyc < MAXC) begin
            bit ok;
            bit idle_ok;
`ifdef FFT_REORDER_XPROP_EN
            idle_ok = (do_re === 16'bx) && (do_im === 16'bx);
`else
            idle_ok = (do_re === 16'h0) && (do_im === 16'h0);
`endif
            if (exp_en[cyc]) begin
                ok = (do_en === 1'b1) && (do_re === exp_re[cyc]) && (do_im === exp_im[cyc]);
            end else begin
                ok = (do_en === 1'b0) && idle_ok;
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL cycle %0d: got en=%b re=%h im=%h, want en=%b re=%h im=%h",
                         cyc, do_en, do_re, do_im, exp_en[cyc],
                         exp_en[cyc] ? exp_re[cyc] : 16'h0,
                         exp_en[cyc] ? exp_im[cyc] : 16'h0);
            end
            if (do_en === 1'b1) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
        end
    end

    initial begin
        int c, ca, cb;
        for (int t = 0; t < MAXC; t++) begin
            exp_en[t] = 1'b0;
            exp_re[t] = '0;
            exp_im[t] = '0;
        end

        // Pin the shared helper.
        check("bitrev_1", int'(bitrev(8'd1)), 128);
        check("bitrev_3", int'(bitrev(8'd3)), 192);
        check("bitrev_200", int'(bitrev(8'd200)), 19);

        tick(1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b0, '0, '0);
        tick(1'b0, 1'b0, '0, '0);
        idle(4);

        // Single frame with recognisable data.
        send_frame(256, 0, 0);
        c = last_done;
        check("model_single_en_c1", int'(exp_en[c + 1]), 0);
        check("model_single_en_first", int'(exp_en[c + 2]), 1);
        check("model_single_re_m1", int'(exp_re[c + 3]), 1);
        check("model_single_im_m1", int'(exp_im[c + 3]), 128);
        check("model_single_re_m255", int'(exp_re[c + 257]), 255);
        check("model_single_en_after", int'(exp_en[c + 258]), 0);
        idle(270);
        check("single_max_run", max_run, 256);

        // Four back-to-back frames.
        for (int f = 0; f < 4; f++) send_frame(256, 1, f);
        idle(270);
        check("b2b_max_run", max_run, 1024);

        // Partial frame discarded, then full frame.
        max_run = 0;
        send_frame(100, 2, 0);
        idle(5);
        send_frame(256, 2, 0);
        idle(270);
        check("partial_run", max_run, 256);

        // Reset in the cycle that presents read index 50.
        send_frame(256, 2, 0);
        c = last_done;
        while (cyc < c + 51) idle(1);
        tick(1'b1, 1'b0, '0, '0);
        check("model_reset_en_next", int'(exp_en[c + 53]), 0);
        idle(3);
        send_frame(256, 2, 0);
        idle(270);

        // 37-cycle gap between frames.
        send_frame(256, 2, 0);
        ca = last_done;
        idle(37);
        send_frame(256, 2, 0);
        cb = last_done;
        check("model_gap_en_last", int'(exp_en[ca + 257]), 1);
        check("model_gap_en_gap", int'(exp_en[ca + 258]), 0);
        check("model_gap_len", (cb + 2) - (ca + 258), 37);
        idle(270);

        // Random mix of partial frames, full frames and gaps.
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_frame(int'($urandom_range(1, 255)), 2, 0);
                idle(int'($urandom_range(1, 10)));
            end
            send_frame(256, 2, 0);
            idle(int'($urandom_range(0, 40)));
        end
        idle(270);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
